// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a built-in baud divider and a transmit FIFO.
// Every frame uses the settings present when its word leaves the FIFO, so
// settings can change while a frame is being sent.
//
// Parameters:
//   DATA_WIDTH      maximum data bits per frame and width of wr_data
//   DEPTH           FIFO depth in words (power of 2, >= 2)
//   DIV_WIDTH       width of baud_divisor
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-high reset
//   baud_divisor    bit period is baud_divisor+1 clock cycles
//   data_length     data bits per frame; 0 or > DATA_WIDTH selects DATA_WIDTH
//   parity_enable   1 = a parity bit follows the data bits
//   parity_type     0 = even parity, 1 = odd parity
//   two_stop_bits   0 = one stop bit, 1 = two stop bits
//   wr_valid        write request
//   wr_data         word to queue
//   wr_ready        FIFO not full
//   serial_data_out registered TX line, idles high
//   busy            a frame is being sent
//   tx_done         one-cycle pulse after the last stop bit of each frame
//   fifo_count      number of words waiting in the FIFO
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DIV_WIDTH-1:0]    baud_divisor,
   input  logic [3:0]              data_length,
   input  logic                    parity_enable,
   input  logic                    parity_type,
   input  logic                    two_stop_bits,
   input  logic                    wr_valid,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    wr_ready,
   output logic                    serial_data_out,
   output logic                    busy,
   output logic                    tx_done,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // FIFO storage
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;

   // Transmitter state; everything here is latched when a word is popped
   state_t                r_state;
   logic [DIV_WIDTH-1:0]  r_div;
   logic [DIV_WIDTH-1:0]  r_baud_cnt;
   logic [LW-1:0]         r_len;
   logic [LW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_parity_bit;
   logic                  r_par_en;
   logic                  r_two_stop;
   logic                  r_second_stop;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_tx_done;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_bit_end;
   logic                  w_frame_end;
   logic [LW-1:0]         w_len;
   logic [DATA_WIDTH-1:0] w_head;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic                  w_head_parity;

   assign wr_ready        = (r_count != (AW+1)'(DEPTH));
   assign w_push          = wr_valid && wr_ready;
   assign w_head          = r_mem[r_rd_ptr];
   assign w_bit_end       = (r_baud_cnt == '0);
   assign w_frame_end     = (r_state == S_STOP) && w_bit_end && (!r_two_stop || r_second_stop);
   // Pop from IDLE, or on the last stop-bit edge so the next start bit follows immediately
   assign w_pop           = (r_count != '0) && ((r_state == S_IDLE) || w_frame_end);
   assign w_shift_next    = r_shift >> 1;

   assign serial_data_out = r_tx;
   assign busy            = r_busy;
   assign tx_done         = r_tx_done;
   assign fifo_count      = r_count;

   // Clamp the requested length and build a mask of the bits that will be sent
   always_comb begin
      w_len  = LW'(DATA_WIDTH);
      w_mask = '0;
      if (data_length != 4'd0 && 32'(data_length) <= DATA_WIDTH) begin
         w_len = LW'(data_length);
      end
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         w_mask[i] = (i < 32'(w_len));
      end
      w_head_parity = (^(w_head & w_mask)) ^ parity_type;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_div         <= '0;
         r_baud_cnt    <= '0;
         r_len         <= '0;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_parity_bit  <= 1'b0;
         r_par_en      <= 1'b0;
         r_two_stop    <= 1'b0;
         r_second_stop <= 1'b0;
         r_tx          <= 1'b1;
         r_busy        <= 1'b0;
         r_tx_done     <= 1'b0;
      end else begin
         r_tx_done <= w_frame_end;
         if (w_pop) begin
            // Start a new frame with a snapshot of the current settings
            r_state       <= S_START;
            r_shift       <= w_head;
            r_div         <= baud_divisor;
            r_baud_cnt    <= baud_divisor;
            r_len         <= w_len;
            r_bit_cnt     <= '0;
            r_parity_bit  <= w_head_parity;
            r_par_en      <= parity_enable;
            r_two_stop    <= two_stop_bits;
            r_second_stop <= 1'b0;
            r_tx          <= 1'b0;
            r_busy        <= 1'b1;
         end else if (r_state != S_IDLE) begin
            if (!w_bit_end) begin
               r_baud_cnt <= r_baud_cnt - 1'b1;
            end else begin
               r_baud_cnt <= r_div;
               case (r_state)
                  S_START: begin
                     r_state <= S_DATA;
                     r_tx    <= r_shift[0];
                  end
                  S_DATA: begin
                     if (r_bit_cnt == r_len - 1'b1) begin
                        if (r_par_en) begin
                           r_state <= S_PARITY;
                           r_tx    <= r_parity_bit;
                        end else begin
                           r_state <= S_STOP;
                           r_tx    <= 1'b1;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_shift   <= w_shift_next;
                        r_tx      <= w_shift_next[0];
                     end
                  end
                  S_PARITY: begin
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
                  end
                  S_STOP: begin
                     if (r_two_stop && !r_second_stop) begin
                        r_second_stop <= 1'b1;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_tx    <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule
